// File: rtl/viterbi_pkg.sv
// Shared constants, encoder model and FSM state type for the K=7 rate-1/2 Viterbi decoder.
package viterbi_pkg;

    localparam int unsigned K          = 7;
    localparam int unsigned STATE_W    = K - 1;
    localparam int unsigned NUM_STATES = 1 << STATE_W;

    // Tap masks over {b, s[5:0]}, newest input bit at the MSB
    localparam logic [K-1:0] G0 = 7'o133;
    localparam logic [K-1:0] G1 = 7'o171;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } fsm_e;

    // Returns {A, B} for input bit b leaving encoder state s
    function automatic logic [1:0] enc_out(input logic [STATE_W-1:0] s, input logic b);
        return {^({b, s} & G0), ^({b, s} & G1)};
    endfunction

endpackage

// File: rtl/viterbi_decoder_k7_if.sv
// Symbol-in / bit-out bus of viterbi_decoder_k7; erasure flags exist only with VITERBI_ERASURE_EN.
interface viterbi_decoder_k7_if;

    logic In_Valid;
    logic In_Ready;
    logic In_A;
    logic In_B;
    logic In_Last;
`ifdef VITERBI_ERASURE_EN
    logic In_EraseA;
    logic In_EraseB;
`endif
    logic Out_Valid;
    logic Out_Data;
    logic Out_Last;

`ifdef VITERBI_ERASURE_EN
    modport master (output In_Valid, In_A, In_B, In_Last, In_EraseA, In_EraseB,
                    input  In_Ready, Out_Valid, Out_Data, Out_Last);
    modport slave  (input  In_Valid, In_A, In_B, In_Last, In_EraseA, In_EraseB,
                    output In_Ready, Out_Valid, Out_Data, Out_Last);
`else
    modport master (output In_Valid, In_A, In_B, In_Last,
                    input  In_Ready, Out_Valid, Out_Data, Out_Last);
    modport slave  (input  In_Valid, In_A, In_B, In_Last,
                    output In_Ready, Out_Valid, Out_Data, Out_Last);
`endif

endinterface

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; ties keep the even predecessor.
module viterbi_acs
    import viterbi_pkg::*;
#(
    parameter int unsigned TB_DEPTH     = 36,
    parameter int unsigned METRIC_WIDTH = 8
) (
    input  logic [METRIC_WIDTH-1:0] pm0_i,
    input  logic [METRIC_WIDTH-1:0] pm1_i,
    input  logic [TB_DEPTH-2:0]     path0_i,
    input  logic [TB_DEPTH-2:0]     path1_i,
    input  logic [1:0]              bm0_i,
    input  logic [1:0]              bm1_i,
    input  logic                    new_bit_i,
    output logic [METRIC_WIDTH-1:0] pm_c_o,
    output logic [TB_DEPTH-1:0]     path_c_o
);

    logic [METRIC_WIDTH-1:0] cand0_c;
    logic [METRIC_WIDTH-1:0] cand1_c;
    logic                    take1_c;

    assign cand0_c  = pm0_i + METRIC_WIDTH'(bm0_i);
    assign cand1_c  = pm1_i + METRIC_WIDTH'(bm1_i);
    assign take1_c  = cand1_c < cand0_c;
    assign pm_c_o   = take1_c ? cand1_c : cand0_c;
    assign path_c_o = {take1_c ? path1_i : path0_i, new_bit_i};

endmodule

// File: rtl/viterbi_decoder_k7.sv
// Streaming register-exchange Viterbi decoder, K=7 rate 1/2, framed with tail flush from state 0.
// Build option VITERBI_ERASURE_EN adds per-bit erasure flags that zero that bit's branch metric.
module viterbi_decoder_k7
    import viterbi_pkg::*;
#(
    parameter int unsigned TB_DEPTH     = 36,
    parameter int unsigned METRIC_WIDTH = 8
) (
    input  logic                 Clock,
    input  logic                 Reset,
    viterbi_decoder_k7_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(TB_DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(TB_DEPTH);
    localparam logic [METRIC_WIDTH-1:0] PM_INIT = METRIC_WIDTH'(1 << (METRIC_WIDTH - 2));

    fsm_e                    state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    ready_q, ready_d;
    logic                    out_valid_q, out_valid_d;
    logic                    out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;

    logic [METRIC_WIDTH-1:0] pm_q     [NUM_STATES];
    logic [METRIC_WIDTH-1:0] pm_d     [NUM_STATES];
    logic [METRIC_WIDTH-1:0] pm_src   [NUM_STATES];
    logic [METRIC_WIDTH-1:0] pm_acs   [NUM_STATES];
    logic [TB_DEPTH-1:0]     path_q   [NUM_STATES];
    logic [TB_DEPTH-1:0]     path_d   [NUM_STATES];
    logic [TB_DEPTH-2:0]     path_src [NUM_STATES];
    logic [TB_DEPTH-1:0]     path_acs [NUM_STATES];

    logic [1:0]              bm_tab   [4];
    logic                    accept_c;
    logic                    era_c, erb_c;
    logic                    all_msb_c;
    logic [STATE_W-1:0]      min_idx_c;
    logic [METRIC_WIDTH-1:0] min_pm_c;
    logic [IDX_W-1:0]        flush_idx_c;

    function automatic logic [1:0] branch_metric(input logic [1:0] exp_ab, input logic a,
                                                 input logic b, input logic era, input logic erb);
        return {1'b0, ~era & (a ^ exp_ab[1])} + {1'b0, ~erb & (b ^ exp_ab[0])};
    endfunction

`ifdef VITERBI_ERASURE_EN
    assign era_c = bus.In_EraseA;
    assign erb_c = bus.In_EraseB;
`else
    assign era_c = 1'b0;
    assign erb_c = 1'b0;
`endif

    assign accept_c      = bus.In_Valid & ready_q;
    assign bus.In_Ready  = ready_q;
    assign bus.Out_Valid = out_valid_q;
    assign bus.Out_Data  = out_data_q;
    assign bus.Out_Last  = out_last_q;

    // Only four distinct {A,B} hypotheses exist, so every branch indexes this table
    always_comb begin
        for (int unsigned e = 0; e < 4; e++) begin
            bm_tab[e] = branch_metric(2'(e), bus.In_A, bus.In_B, era_c, erb_c);
        end
    end

    // First symbol of a frame starts from a fresh trellis biased towards state 0
    always_comb begin
        for (int unsigned i = 0; i < NUM_STATES; i++) begin
            if (state_q == ST_IDLE) begin
                pm_src[i]   = (i == 0) ? '0 : PM_INIT;
                path_src[i] = '0;
            end else begin
                pm_src[i]   = pm_q[i];
                path_src[i] = path_q[i][TB_DEPTH-2:0];
            end
        end
    end

    for (genvar n = 0; n < NUM_STATES; n++) begin : g_acs
        localparam logic [STATE_W-1:0] P0 = STATE_W'((2 * n) % NUM_STATES);
        localparam logic [STATE_W-1:0] P1 = P0 | STATE_W'(1);
        localparam logic               NB = (n >= NUM_STATES / 2);
        localparam logic [1:0]         E0 = enc_out(P0, NB);
        localparam logic [1:0]         E1 = enc_out(P1, NB);

        viterbi_acs #(
            .TB_DEPTH     (TB_DEPTH),
            .METRIC_WIDTH (METRIC_WIDTH)
        ) u_acs (
            .pm0_i     (pm_src[P0]),
            .pm1_i     (pm_src[P1]),
            .path0_i   (path_src[P0]),
            .path1_i   (path_src[P1]),
            .bm0_i     (bm_tab[E0]),
            .bm1_i     (bm_tab[E1]),
            .new_bit_i (NB),
            .pm_c_o    (pm_acs[n]),
            .path_c_o  (path_acs[n])
        );
    end

    // Metrics only ever compare relatively, so dropping a shared MSB preserves ordering
    always_comb begin
        all_msb_c = 1'b1;
        for (int unsigned i = 0; i < NUM_STATES; i++) begin
            all_msb_c = all_msb_c & pm_acs[i][METRIC_WIDTH-1];
        end
        for (int unsigned i = 0; i < NUM_STATES; i++) begin
            pm_d[i]   = pm_q[i];
            path_d[i] = path_q[i];
            if (accept_c) begin
                pm_d[i]   = pm_acs[i];
                path_d[i] = path_acs[i];
                if (all_msb_c) begin
                    pm_d[i][METRIC_WIDTH-1] = 1'b0;
                end
            end
        end
    end

    // Best state before the update; strict compare keeps the lowest index on ties
    always_comb begin
        min_idx_c = '0;
        min_pm_c  = pm_q[0];
        for (int unsigned i = 1; i < NUM_STATES; i++) begin
            if (pm_q[i] < min_pm_c) begin
                min_pm_c  = pm_q[i];
                min_idx_c = STATE_W'(i);
            end
        end
    end

    assign flush_idx_c = IDX_W'(cnt_q - CNT_W'(1));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        out_data_d  = 1'b0;
        out_last_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    cnt_d   = CNT_W'(1);
                    state_d = bus.In_Last ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept_c) begin
                    if (cnt_q == CNT_W'(TB_DEPTH)) begin
                        out_valid_d = 1'b1;
                        out_data_d  = path_q[min_idx_c][TB_DEPTH-1];
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (bus.In_Last) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: begin
                // cnt_q holds the bits still buffered in state 0's survivor
                out_valid_d = 1'b1;
                out_data_d  = path_q[0][flush_idx_c];
                cnt_d       = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    out_last_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d != ST_FLUSH);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ready_q     <= ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Trellis storage needs no reset: IDLE substitutes fresh values on a frame's first symbol
    always_ff @(posedge Clock) begin
        pm_q   <= pm_d;
        path_q <= path_d;
    end

endmodule

// File: doc/viterbi_decoder_k7.md
# viterbi_decoder_k7

Streaming hard-decision Viterbi decoder for the 802.11a K=7, rate-1/2 convolutional code (g0=133, g1=171 octal), placed after the deinterleaver/depuncturer in the receive chain. Register-exchange survivor management with parametrised decision depth and metric width. Framed operation: accepts one coded symbol pair per cycle, emits exactly one decoded bit per accepted symbol, and flushes the tail-terminated end of frame from state 0.

## Interface
- TB_DEPTH, 36: survivor register length in bits; also the decode latency in symbols. Legal range 6..64.
- METRIC_WIDTH, 8: path-metric width in bits. Minimum 6.
- Clock  input  1  rising-edge clock
- Reset  input  1  synchronous, active-high reset
- In_Valid  input  1  symbol pair present
- In_Ready  output  1  decoder accepts a symbol this cycle
- In_A  input  1  coded bit from g0
- In_B  input  1  coded bit from g1
- In_Last  input  1  final symbol of the frame (tail included)
- Out_Valid  output  1  Out_Data valid; single-cycle pulse per bit, no backpressure
- Out_Data  output  1  decoded bit
- Out_Last  output  1  final decoded bit of the frame

## Operation
- State s[5:0] holds the last 6 input bits; s[5] is the newest. Transition on input b: next = {b, s[5:1]}. Expected outputs: A = b^s[4]^s[3]^s[1]^s[0], B = b^s[5]^s[4]^s[3]^s[0].
- Branch metric = (In_A != A) + (In_B != B), range 0..2.
- ACS for every state n: predecessors p0={n[4:0],0}, p1={n[4:0],1}. Candidate = PM[p]+BM. Select the smaller candidate; a tie selects p0. Survivor path = selected predecessor's path shifted, with n[5] inserted as the newest bit.
- Normalisation: if every new metric has its MSB set, clear the MSB of all metrics in that same update. The spread stays below 2^(METRIC_WIDTH-1).
- FSM states:
  - IDLE: In_Ready=1. On the first accepted symbol, initialise PM[0]=0, all other PM=2^(METRIC_WIDTH-2), clear paths, and run the ACS on that symbol. Go to RUN, or go directly to FLUSH if In_Last is set.
  - RUN: In_Ready=1. On accepted symbol number k (0-based), with k≥TB_DEPTH, output the oldest path bit of the minimum-metric pre-update state (tie picks the lowest index). That bit is decoded bit k−TB_DEPTH. Accepting a symbol with In_Last set goes to FLUSH.
  - FLUSH: In_Ready=0. Emit the remaining min(N,TB_DEPTH) bits oldest-first from state 0's path, one per cycle. Out_Last is set on the final bit. Then go to IDLE.
- Total outputs per frame = N (the number of accepted symbols), always in order.
- In_Valid=0 in RUN: metrics and paths hold, and there is no output.

## Timing
- Reset values: In_Ready=0 during the reset cycle and 1 afterwards, Out_Valid=0, Out_Data=0, Out_Last=0, FSM=IDLE, symbol counter=0.
- Out_Data, Out_Valid and Out_Last are registered. The output for a symbol accepted at edge t appears after edge t.
- The first flush bit appears in the cycle after the edge that accepts In_Last. Flush lasts min(N,TB_DEPTH) cycles. IDLE resumes the cycle after Out_Last.
- If N < TB_DEPTH, there is no output during RUN. All N bits come out in FLUSH.
- Reset asserted mid-frame or mid-flush takes effect at the next edge. Outputs clear, and partial-frame data is discarded with no Out_Last.
- In_Valid while In_Ready=0 is ignored; upstream must hold the symbol.

## Configuration
- VITERBI_ERASURE_EN defined: adds ports In_EraseA and In_EraseB (input, 1 bit each). An erased bit contributes 0 to the branch metric. This supports depunctured rates 2/3 and 3/4.
- VITERBI_ERASURE_EN undefined: these ports are absent and both bits always count.

## Structure
- Package viterbi_pkg: K=7, STATE_W=6, NUM_STATES=64, the G0/G1 tap constants, an encoder-output function (state, bit → {A,B}), and the FSM state enum.
- Sub-module viterbi_acs: one instance per state via generate. Inputs are two predecessor metrics, two predecessor paths, and the branch metrics. Outputs are the new metric and new path. The minimum-state selector and the FSM stay in the top level.

## Test plan
- 54 symbols of (0,0) with In_Last on the 54th → 54 zero bits, Out_Last on the 54th, and In_Ready returns to 1 afterwards.
- Bits 1,0,1,1 plus 6 zero tail bits, encoded by the model (first symbol (1,1)) → decoded 1,0,1,1,0,0,0,0,0,0. All bits come out in flush because N=10 < TB_DEPTH.
- 200 random bits plus tail, with single errors injected at symbols 10, 80 and 150 → error-free output. The first Out_Valid comes one cycle after the edge that accepts symbol 36.
- 5000-symbol frame with a 5% random bit-error rate → metrics never wrap, normalisation is observed, and output matches the reference decoder model.
- Reset asserted on symbol 100 of a 300-symbol frame → Out_Valid=0 on the next cycle and no Out_Last. A following 54-symbol all-zero frame decodes correctly.
- With VITERBI_ERASURE_EN: a rate-3/4 punctured random frame with erasures marked → matches the unpunctured source bits.
